// File: rtl/fmul_pipe.sv
// Pipelined IEEE-754 binary floating-point multiplier with generic exponent/fraction widths.
// Three compute stages (unpack/classify, mantissa product, normalise) feed a round/pack
// output register, so an item accepted on edge N is presented after edge N+3.
// Denormal inputs are flushed to zero and tiny results flush to signed zero.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready = !out_valid | out_ready)
//   op1, op2            packed operands {sign, exp, frac}
//   opc                 00 mul, 01 negated mul, 10 abs-value mul, 11 illegal
//   rmode               00 RNE, 01 RTZ, 10 RUP, 11 RDN
//   out_valid/out_ready result handshake
//   result, flags       packed product and {nv, of, uf, nx}
module fmul_pipe #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MANT_W = 23
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+MANT_W:0]   op1,
  input  logic [EXP_W+MANT_W:0]   op2,
  input  logic [1:0]              opc,
  input  logic [1:0]              rmode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W:0]   result,
  output logic [3:0]              flags
);

  localparam int unsigned W    = 1 + EXP_W + MANT_W;
  localparam int unsigned EXW  = EXP_W + 2;
  localparam int unsigned PW   = 2 * MANT_W + 2;
  localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned EMAX = (1 << EXP_W) - 1;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_NMUL = 2'b01;
  localparam logic [1:0] OP_ILL  = 2'b11;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

  // Operand class; also reused as the resolved special-result kind (NORM = no special).
  typedef enum logic [1:0] {CL_NORM, CL_ZERO, CL_INF, CL_NAN} cls_e;

  function automatic cls_e classify(input logic [EXP_W-1:0] e, input logic [MANT_W-1:0] f);
    if (e == '1)      return (f != '0) ? CL_NAN : CL_INF;
    else if (e == '0) return CL_ZERO;
    else              return CL_NORM;
  endfunction

  // Global stall: every stage advances together only when the output slot frees up.
  logic en_c;
  assign en_c     = !out_valid || out_ready;
  assign in_ready = en_c;

  // ---------------- Stage 1: unpack / classify ----------------
  logic [EXP_W-1:0]  e1_c, e2_c;
  logic [MANT_W-1:0] f1_c, f2_c;
  logic              s1_sign_d;
  logic [EXW-1:0]    s1_exp_d;

  assign e1_c = op1[W-2 -: EXP_W];
  assign e2_c = op2[W-2 -: EXP_W];
  assign f1_c = op1[MANT_W-1:0];
  assign f2_c = op2[MANT_W-1:0];
  // Biased exponent sum kept in EXW bits; negative values wrap and are caught by the MSB.
  assign s1_exp_d = EXW'(e1_c) + EXW'(e2_c) - EXW'(BIAS);

  always_comb begin
    s1_sign_d = 1'b0;
    case (opc)
      OP_MUL:  s1_sign_d = op1[W-1] ^ op2[W-1];
      OP_NMUL: s1_sign_d = ~(op1[W-1] ^ op2[W-1]);
      default: s1_sign_d = 1'b0;
    endcase
  end

  logic              s1_valid_q, s1_sign_q, s1_ill_q;
  logic [EXW-1:0]    s1_exp_q;
  logic [MANT_W:0]   s1_m1_q, s1_m2_q;
  cls_e              s1_cls1_q, s1_cls2_q;
  logic [1:0]        s1_rm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_ill_q   <= 1'b0;
      s1_exp_q   <= '0;
      s1_m1_q    <= '0;
      s1_m2_q    <= '0;
      s1_cls1_q  <= CL_NORM;
      s1_cls2_q  <= CL_NORM;
      s1_rm_q    <= RM_RNE;
    end else if (en_c) begin
      s1_valid_q <= in_valid;
      s1_sign_q  <= s1_sign_d;
      s1_ill_q   <= (opc == OP_ILL);
      s1_exp_q   <= s1_exp_d;
      s1_m1_q    <= {1'b1, f1_c};
      s1_m2_q    <= {1'b1, f2_c};
      s1_cls1_q  <= classify(e1_c, f1_c);
      s1_cls2_q  <= classify(e2_c, f2_c);
      s1_rm_q    <= rmode;
    end
  end

  // ---------------- Stage 2: mantissa product, special resolution ----------------
  logic [PW-1:0] s2_prod_d;
  cls_e          s2_spec_d;
  logic          s2_nv_d;

  assign s2_prod_d = PW'(s1_m1_q) * PW'(s1_m2_q);

  always_comb begin
    s2_spec_d = CL_NORM;
    s2_nv_d   = 1'b0;
    if (s1_ill_q) begin
      s2_spec_d = CL_NAN;
      s2_nv_d   = 1'b1;
    end else if (s1_cls1_q == CL_NAN || s1_cls2_q == CL_NAN) begin
      s2_spec_d = CL_NAN;
    end else if ((s1_cls1_q == CL_INF && s1_cls2_q == CL_ZERO) ||
                 (s1_cls1_q == CL_ZERO && s1_cls2_q == CL_INF)) begin
      s2_spec_d = CL_NAN;
      s2_nv_d   = 1'b1;
    end else if (s1_cls1_q == CL_INF || s1_cls2_q == CL_INF) begin
      s2_spec_d = CL_INF;
    end else if (s1_cls1_q == CL_ZERO || s1_cls2_q == CL_ZERO) begin
      s2_spec_d = CL_ZERO;
    end
  end

  logic           s2_valid_q, s2_sign_q, s2_nv_q;
  logic [EXW-1:0] s2_exp_q;
  logic [PW-1:0]  s2_prod_q;
  cls_e           s2_spec_q;
  logic [1:0]     s2_rm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_nv_q    <= 1'b0;
      s2_exp_q   <= '0;
      s2_prod_q  <= '0;
      s2_spec_q  <= CL_NORM;
      s2_rm_q    <= RM_RNE;
    end else if (en_c) begin
      s2_valid_q <= s1_valid_q;
      s2_sign_q  <= s1_sign_q;
      s2_nv_q    <= s2_nv_d;
      s2_exp_q   <= s1_exp_q;
      s2_prod_q  <= s2_prod_d;
      s2_spec_q  <= s2_spec_d;
      s2_rm_q    <= s1_rm_q;
    end
  end

  // ---------------- Stage 3: normalise to 1.f with guard and sticky ----------------
  logic [MANT_W-1:0] s3_frac_d;
  logic              s3_g_d, s3_s_d;
  logic [EXW-1:0]    s3_exp_d;

  // Product of two [1,2) significands lies in [1,4); bit PW-1 set means >= 2.
  always_comb begin
    s3_frac_d = s2_prod_q[PW-3 -: MANT_W];
    s3_g_d    = s2_prod_q[MANT_W-1];
    s3_s_d    = |s2_prod_q[MANT_W-2:0];
    s3_exp_d  = s2_exp_q;
    if (s2_prod_q[PW-1]) begin
      s3_frac_d = s2_prod_q[PW-2 -: MANT_W];
      s3_g_d    = s2_prod_q[MANT_W];
      s3_s_d    = |s2_prod_q[MANT_W-1:0];
      s3_exp_d  = s2_exp_q + EXW'(1);
    end
  end

  logic              s3_valid_q, s3_sign_q, s3_nv_q, s3_g_q, s3_s_q;
  logic [EXW-1:0]    s3_exp_q;
  logic [MANT_W-1:0] s3_frac_q;
  cls_e              s3_spec_q;
  logic [1:0]        s3_rm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_q <= 1'b0;
      s3_sign_q  <= 1'b0;
      s3_nv_q    <= 1'b0;
      s3_g_q     <= 1'b0;
      s3_s_q     <= 1'b0;
      s3_exp_q   <= '0;
      s3_frac_q  <= '0;
      s3_spec_q  <= CL_NORM;
      s3_rm_q    <= RM_RNE;
    end else if (en_c) begin
      s3_valid_q <= s2_valid_q;
      s3_sign_q  <= s2_sign_q;
      s3_nv_q    <= s2_nv_q;
      s3_g_q     <= s3_g_d;
      s3_s_q     <= s3_s_d;
      s3_exp_q   <= s3_exp_d;
      s3_frac_q  <= s3_frac_d;
      s3_spec_q  <= s2_spec_q;
      s3_rm_q    <= s2_rm_q;
    end
  end

  // ---------------- Round, range check and pack ----------------
  logic              inc_c, rnd_carry_c, to_inf_c, inexact_c;
  logic [MANT_W-1:0] rnd_frac_c;
  logic [EXW-1:0]    rnd_exp_c;
  logic [W-1:0]      res_d;
  logic [3:0]        flg_d;

  always_comb begin
    inexact_c = s3_g_q || s3_s_q;
    inc_c     = 1'b0;
    case (s3_rm_q)
      RM_RNE:  inc_c = s3_g_q && (s3_s_q || s3_frac_q[0]);
      RM_RTZ:  inc_c = 1'b0;
      RM_RUP:  inc_c = inexact_c && !s3_sign_q;
      RM_RDN:  inc_c = inexact_c && s3_sign_q;
      default: inc_c = 1'b0;
    endcase
    {rnd_carry_c, rnd_frac_c} = {1'b0, s3_frac_q} + (MANT_W+1)'(inc_c);
    rnd_exp_c = s3_exp_q + EXW'(rnd_carry_c);
    to_inf_c  = (s3_rm_q == RM_RNE) ||
                (s3_rm_q == RM_RUP && !s3_sign_q) ||
                (s3_rm_q == RM_RDN && s3_sign_q);

    res_d = '0;
    flg_d = '0;
    if (s3_spec_q == CL_NAN) begin
      res_d = QNAN;
      flg_d = {s3_nv_q, 3'b000};
    end else if (s3_spec_q == CL_INF) begin
      res_d = {s3_sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (s3_spec_q == CL_ZERO) begin
      res_d = {s3_sign_q, {(W-1){1'b0}}};
    end else if (s3_exp_q[EXW-1] || s3_exp_q == '0) begin
      // Negative (wrapped) or zero biased exponent: flush to signed zero.
      res_d = {s3_sign_q, {(W-1){1'b0}}};
      flg_d = 4'b0011;
    end else if (rnd_exp_c >= EXW'(EMAX)) begin
      res_d = to_inf_c ? {s3_sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}}
                       : {s3_sign_q, EXP_W'(EMAX - 1), {MANT_W{1'b1}}};
      flg_d = 4'b0101;
    end else begin
      res_d = {s3_sign_q, rnd_exp_c[EXP_W-1:0], rnd_frac_c};
      flg_d = {3'b000, inexact_c};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (en_c) begin
      out_valid <= s3_valid_q;
      result    <= res_d;
      flags     <= flg_d;
    end
  end

endmodule

// File: tb/tb_fmul_pipe.sv
// Bench for fmul_pipe (FP32 configuration): directed cases with known answers, a stalled
// stream, an asynchronous reset with items in flight, and a randomized run scored against
// an exact-arithmetic reference model.
module tb_fmul_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] op1, op2, result;
  logic [1:0]  opc, rmode;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  always #5 clk = ~clk;

  fmul_pipe #(.EXP_W(8), .MANT_W(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .opc       (opc),
    .rmode     (rmode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: exact integer product of significands, rounded by comparing the discarded
  // remainder against one half ulp. Returns {flags, result}.
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] o, input logic [1:0] r);
    logic s;
    int ea, eb, e, lead, sh;
    longint unsigned p, kept, rem, half;
    bit an, bn, ai, bi, az, bz, nx, up, to_inf;
    if (o == 2'b11) return {4'b1000, QNAN};
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    az = (ea == 0);
    bz = (eb == 0);
    s  = (o == 2'b00) ? (a[31] ^ b[31]) : (o == 2'b01) ? ~(a[31] ^ b[31]) : 1'b0;
    if (an || bn) return {4'b0000, QNAN};
    if ((ai && bz) || (az && bi)) return {4'b1000, QNAN};
    if (ai || bi) return {4'b0000, s, 8'hFF, 23'h0};
    if (az || bz) return {4'b0000, s, 31'h0};
    p    = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
    lead = ((p >> 47) != 0) ? 47 : 46;
    e    = lead - 46 + ea + eb - 127;
    if (e <= 0) return {4'b0011, s, 31'h0};
    sh   = lead - 23;
    kept = p >> sh;
    rem  = p - (kept << sh);
    half = 64'd1 << (sh - 1);
    nx   = (rem != 0);
    case (r)
      2'b00:   up = (rem > half) || ((rem == half) && kept[0]);
      2'b01:   up = 1'b0;
      2'b10:   up = nx && !s;
      default: up = nx && s;
    endcase
    kept = kept + 64'(up);
    if (kept == (64'd1 << 24)) begin
      kept = kept >> 1;
      e    = e + 1;
    end
    if (e >= 255) begin
      to_inf = (r == 2'b00) || (r == 2'b10 && !s) || (r == 2'b11 && s);
      return {4'b0101, to_inf ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF}};
    end
    return {3'b000, nx, s, 8'(e), kept[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    int k;
    logic [7:0]  e;
    logic [22:0] f;
    k = int'($urandom_range(0, 19));
    f = 23'($urandom);
    if (k == 0)      e = 8'h00;
    else if (k == 1) begin e = 8'hFF; f = '0; end
    else if (k == 2) begin e = 8'hFF; f = f | 23'h1; end
    else if (k == 3) e = 8'($urandom_range(200, 254));
    else if (k == 4) e = 8'($urandom_range(1, 40));
    else if (k == 5) begin e = 8'($urandom_range(100, 150)); f = 23'h7FFFFF; end
    else             e = 8'($urandom_range(64, 190));
    return {1'($urandom), e, f};
  endfunction

  // Scoreboard monitor: model pushed on input transfer, compared on output transfer.
  logic [35:0] exp_q[$];
  logic        hold_v = 1'b0;
  logic [35:0] hold_d;
  always @(negedge clk) begin
    logic [35:0] e;
    if (!rst_n) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_stable", 64'({flags, result}), 64'(hold_d));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_output", 64'(out_valid), 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("result_vs_model", 64'({flags, result}), 64'(e));
        end
        n_out++;
      end
      hold_v = out_valid && !out_ready;
      hold_d = {flags, result};
      if (in_valid && in_ready) exp_q.push_back(ref_mul(op1, op2, opc, rmode));
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] o, input logic [1:0] r);
    int guard = 0;
    op1 = a; op2 = b; opc = o; rmode = r; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) chk("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] o, input logic [1:0] r,
                         input logic [31:0] er, input logic [3:0] ef, input bit chk_lat);
    int lat = 0;
    send(a, b, o, r);
    while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    if (chk_lat) chk({tag, "_latency"}, 64'(lat), 64'd3);
    chk({tag, "_result"}, 64'(result), 64'(er));
    chk({tag, "_flags"}, 64'(flags), 64'(ef));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] sa[8], sb[8];
    logic [1:0]  so[8], sr[8];
    int idx, stalls, base;
    logic acc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op1 = '0; op2 = '0; opc = '0; rmode = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_flags", 64'(flags), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // Directed known-answer cases
    run_one("mul_3",      32'h3FC00000, 32'h40000000, 2'b00, 2'b00, 32'h40400000, 4'b0000, 1'b1);
    run_one("eps_rne",    32'h3F800001, 32'h3F800001, 2'b00, 2'b00, 32'h3F800002, 4'b0001, 1'b1);
    run_one("eps_rup",    32'h3F800001, 32'h3F800001, 2'b00, 2'b10, 32'h3F800003, 4'b0001, 1'b0);
    run_one("eps_rtz",    32'h3F800001, 32'h3F800001, 2'b00, 2'b01, 32'h3F800002, 4'b0001, 1'b0);
    run_one("ovf_rne",    32'h7F7FFFFF, 32'h40000000, 2'b00, 2'b00, 32'h7F800000, 4'b0101, 1'b0);
    run_one("ovf_rtz",    32'h7F7FFFFF, 32'h40000000, 2'b00, 2'b01, 32'h7F7FFFFF, 4'b0101, 1'b0);
    run_one("ovf_neg_rdn",32'h7F7FFFFF, 32'h40000000, 2'b01, 2'b11, 32'hFF800000, 4'b0101, 1'b0);
    run_one("inf_x_zero", 32'h7F800000, 32'h00000000, 2'b00, 2'b00, 32'h7FC00000, 4'b1000, 1'b0);
    run_one("underflow",  32'h00800000, 32'h00800000, 2'b00, 2'b00, 32'h00000000, 4'b0011, 1'b0);
    run_one("illegal_op", 32'h3F800000, 32'h3F800000, 2'b11, 2'b00, 32'h7FC00000, 4'b1000, 1'b0);
    run_one("abs_mul",    32'hC0000000, 32'h3FC00000, 2'b10, 2'b00, 32'h40400000, 4'b0000, 1'b0);

    // Back-to-back stream with the consumer stalled in cycles 4..7
    for (int i = 0; i < 8; i++) begin
      sa[i] = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
      sb[i] = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
      so[i] = 2'($urandom_range(0, 2));
      sr[i] = 2'($urandom_range(0, 3));
    end
    base = n_out; idx = 0; stalls = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 4 && c <= 7);
      if (idx < 8) begin
        in_valid = 1'b1; op1 = sa[idx]; op2 = sb[idx]; opc = so[idx]; rmode = sr[idx];
      end else in_valid = 1'b0;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        stalls++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_accepted", 64'(idx), 64'd8);
    chk("stream_out_count", 64'(n_out - base), 64'd8);
    chk("stream_stall_seen", 64'(stalls > 0), 64'd1);

    // Asynchronous reset with three items in flight, one already presented
    out_ready = 1'b0;
    send(32'h3FC00000, 32'h40000000, 2'b00, 2'b00);
    send(32'h40000000, 32'h40000000, 2'b00, 2'b00);
    send(32'h40400000, 32'h40000000, 2'b00, 2'b00);
    @(posedge clk); #1;
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 64'(out_valid), 64'd0);
    chk("async_reset_result", 64'(result), 64'd0);
    chk("async_reset_flags", 64'(flags), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("no_stale_output", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;

    // Randomized traffic with random bubbles and backpressure
    for (int c = 0; c < 600; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 4) != 0);
      op1   = rnd_op();
      op2   = rnd_op();
      opc   = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      rmode = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
